cgp_eval_ctrl: RTL and testbench



---
 rtl/cgp_eval_pkg.sv | 24 ++
 rtl/cgp_popcount.sv | 19 +
 rtl/cgp_eval_ctrl.sv | 126 ++++++++++++
 tb/tb_cgp_eval_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cgp_eval_pkg.sv
// Shared types and helpers for the CGP evaluation controller.
// Holds the FSM state encoding, default widths and a saturating accumulator.
package cgp_eval_pkg;

   localparam int VEC_W_DEF = 10;
   localparam int ERR_W     = 14;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   // Saturating add used by every bit-count accumulator in the block.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                input logic [ERR_W-1:0] inc);
      logic [ERR_W:0] sum;
      sum = {1'b0, acc} + {1'b0, inc};
      return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   endfunction

endpackage

// File: rtl/cgp_popcount.sv
// Parameterised combinational population count.
// Output width is just wide enough to hold W.
module cgp_popcount #(
   parameter int W  = 10,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  i_vec,
   output logic [CW-1:0] o_count
);

   always_comb begin
      // NOTE: assigning a default first keeps combinational blocks latch-free.
      o_count = '0;
      for (int i = 0; i < W; i++) begin
         o_count = o_count + CW'(i_vec[i]);
      end
   end

endmodule

// File: rtl/cgp_eval_ctrl.sv
// Sequences test vectors through a CGP circuit and counts mismatched output bits.
// Optional toggle counter on the sampled outputs is enabled by CGP_EVAL_TOGGLE_EN.
module cgp_eval_ctrl
   import cgp_eval_pkg::*;
#(
   parameter int SETTLE_W = 8,
   parameter int VEC_W    = VEC_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [VEC_W-1:0]    vec_last,
   input  logic [SETTLE_W-1:0] settle,
   output logic [VEC_W-1:0]    dut_in,
   input  logic [VEC_W-1:0]    dut_out,
   output logic [VEC_W-1:0]    exp_addr,
   input  logic [VEC_W-1:0]    exp_data,
   output logic                busy,
   output logic                done,
   output logic [ERR_W-1:0]    err_count
`ifdef CGP_EVAL_TOGGLE_EN
   ,
   output logic [ERR_W-1:0]    tog_count
`endif
);

   localparam int CNT_W = $clog2(VEC_W + 1);

   state_e              r_state;
   state_e              w_next;
   logic [VEC_W-1:0]    r_idx;
   logic [VEC_W-1:0]    r_last;
   logic [SETTLE_W-1:0] r_settle;
   logic [SETTLE_W-1:0] r_cnt;
   logic [ERR_W-1:0]    r_err;
   logic [CNT_W-1:0]    w_err_bits;

   cgp_popcount #(.W(VEC_W)) u_err_pop (
      .i_vec   (dut_out ^ exp_data),
      .o_count (w_err_bits)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments.
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = APPLY;
         APPLY:   w_next = (r_settle != '0) ? SETTLE : SAMPLE;
         SETTLE:  if (r_cnt == SETTLE_W'(1)) w_next = SAMPLE;
         SAMPLE:  w_next = (r_idx == r_last) ? DONE : APPLY;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Run parameters are frozen at start so mid-run input changes are harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_last   <= '0;
         r_settle <= '0;
         r_cnt    <= '0;
         r_err    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx    <= '0;
                  r_err    <= '0;
                  r_last   <= vec_last;
                  r_settle <= settle;
               end
            end
            APPLY:  r_cnt <= r_settle;
            SETTLE: r_cnt <= r_cnt - SETTLE_W'(1);
            SAMPLE: begin
               r_err <= sat_add(r_err, ERR_W'(w_err_bits));
               if (r_idx != r_last) r_idx <= r_idx + VEC_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CGP_EVAL_TOGGLE_EN
   logic [VEC_W-1:0] r_prev;
   logic             r_first;
   logic [ERR_W-1:0] r_tog;
   logic [CNT_W-1:0] w_tog_bits;

   cgp_popcount #(.W(VEC_W)) u_tog_pop (
      .i_vec   (dut_out ^ r_prev),
      .o_count (w_tog_bits)
   );

   // The first sample of a run has no predecessor, so it only seeds r_prev.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= '0;
         r_first <= 1'b1;
         r_tog   <= '0;
      end else if (r_state == IDLE && start) begin
         r_first <= 1'b1;
         r_tog   <= '0;
      end else if (r_state == SAMPLE) begin
         if (!r_first) r_tog <= sat_add(r_tog, ERR_W'(w_tog_bits));
         r_prev  <= dut_out;
         r_first <= 1'b0;
      end
   end

   assign tog_count = r_tog;
`endif

   assign dut_in    = r_idx;
   assign exp_addr  = r_idx;
   assign err_count = r_err;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_cgp_eval_ctrl.sv
// Self-checking bench for cgp_eval_ctrl: table-driven CGP circuit and expected-value
// memory, with run results predicted from the vector tables by plain arithmetic.
module tb_cgp_eval_ctrl;

   localparam int VW = 10;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [VW-1:0] vec_last;
   logic [SW-1:0] settle;
   logic [VW-1:0] dut_in;
   logic [VW-1:0] dut_out;
   logic [VW-1:0] exp_addr;
   logic [VW-1:0] exp_data;
   logic          busy;
   logic          done;
   logic [13:0]   err_count;
`ifdef CGP_EVAL_TOGGLE_EN
   logic [13:0]   tog_count;
`endif

   logic [VW-1:0] dut_tab [1024];
   logic [VW-1:0] exp_tab [1024];

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   cgp_eval_ctrl #(.SETTLE_W(SW), .VEC_W(VW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vec_last  (vec_last),
      .settle    (settle),
      .dut_in    (dut_in),
      .dut_out   (dut_out),
      .exp_addr  (exp_addr),
      .exp_data  (exp_data),
      .busy      (busy),
      .done      (done),
      .err_count (err_count)
`ifdef CGP_EVAL_TOGGLE_EN
      ,
      .tog_count (tog_count)
`endif
   );

   // The circuit under evaluation is a lookup table; expected data has one cycle of latency.
   assign dut_out = dut_tab[dut_in];
   always @(posedge clk) exp_data <= exp_tab[exp_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_err(input int vl);
      int s = 0;
      for (int i = 0; i <= vl; i++) s += $countones(dut_tab[i] ^ exp_tab[i]);
      return (s > 16383) ? 16383 : s;
   endfunction

   function automatic int model_tog(input int vl);
      int s = 0;
      for (int i = 1; i <= vl; i++) s += $countones(dut_tab[i] ^ dut_tab[i-1]);
      return (s > 16383) ? 16383 : s;
   endfunction

   task automatic fill_random(input bit matching);
      for (int i = 0; i < 1024; i++) begin
         dut_tab[i] = VW'($urandom);
         exp_tab[i] = matching ? dut_tab[i] : VW'($urandom);
      end
   endtask

   // One run: start pulse, then a fixed window a few cycles past the expected done.
   // Cycle 0 is the cycle start is high; cycle c is observed c edges later.
   task automatic run(input int vl, input int st, input int poke_cyc,
                      output int done_cyc, output int done_pulses, output int busy_cyc);
      int limit;
      limit       = (vl + 1) * (st + 2) + 6;
      vec_last    = VW'(vl);
      settle      = SW'(st);
      start       = 1'b1;
      tick();
      start       = 1'b0;
      done_cyc    = -1;
      done_pulses = 0;
      busy_cyc    = 0;
      for (int c = 1; c <= limit; c++) begin
         if (busy) busy_cyc++;
         if (done) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == poke_cyc) begin
            start    = 1'b1;
            vec_last = VW'(vl + 7);
            settle   = SW'(st + 3);
         end else if (c == poke_cyc + 1) begin
            start = 1'b0;
         end
         tick();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, dp, bc, vl, st;
      rst      = 1'b1;
      start    = 1'b1;
      vec_last = '0;
      settle   = '0;
      for (int i = 0; i < 1024; i++) begin
         dut_tab[i] = '0;
         exp_tab[i] = '0;
      end
      repeat (3) tick();
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_err", 32'(err_count), 0);
      check("reset_dut_in", 32'(dut_in), 0);
      check("reset_exp_addr", 32'(exp_addr), 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      check("idle_after_reset_busy", 32'(busy), 0);

      // All vectors match, 4 vectors, settle 2.
      fill_random(1'b1);
      run(3, 2, 0, dc, dp, bc);
      check("match_done_cycle", 32'(dc), 17);
      check("match_done_pulses", 32'(dp), 1);
      check("match_busy_cycles", 32'(bc), 17);
      check("match_err", 32'(err_count), 0);
      check("match_dut_in_hold", 32'(dut_in), 3);
      check("match_exp_addr_hold", 32'(exp_addr), 3);

      // Single vector, no settle, one mismatched bit.
      exp_tab[0] = dut_tab[0] ^ 10'h004;
      run(0, 0, 0, dc, dp, bc);
      check("single_done_cycle", 32'(dc), 3);
      check("single_err", 32'(err_count), 1);

      // Randomised runs against the table model.
      for (int k = 0; k < 4; k++) begin
         fill_random(1'b0);
         vl = int'($urandom_range(0, 40));
         st = int'($urandom_range(0, 5));
         run(vl, st, 0, dc, dp, bc);
         check($sformatf("rand%0d_done_cycle", k), 32'(dc), 32'((vl + 1) * (st + 2) + 1));
         check($sformatf("rand%0d_err", k), 32'(err_count), 32'(model_err(vl)));
         check($sformatf("rand%0d_done_pulses", k), 32'(dp), 1);
      end

      // Start re-pulsed and run parameters changed mid-run.
      fill_random(1'b0);
      run(3, 2, 5, dc, dp, bc);
      check("poke_done_cycle", 32'(dc), 17);
      check("poke_done_pulses", 32'(dp), 1);
      check("poke_err", 32'(err_count), 32'(model_err(3)));

      // Reset during SETTLE of vector 5 (vl=9, settle=3: vector 5 settles in cycles 27..29).
      fill_random(1'b0);
      vec_last = VW'(9);
      settle   = SW'(3);
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 28; c++) tick();
      check("pre_reset_busy", 32'(busy), 1);
      check("pre_reset_dut_in", 32'(dut_in), 5);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("midrun_rst_busy", 32'(busy), 0);
      check("midrun_rst_done", 32'(done), 0);
      check("midrun_rst_err", 32'(err_count), 0);
      check("midrun_rst_dut_in", 32'(dut_in), 0);
      check("midrun_rst_exp_addr", 32'(exp_addr), 0);
      tick();
      check("start_with_rst_ignored", 32'(busy), 0);
      run(2, 1, 0, dc, dp, bc);
      check("post_rst_done_cycle", 32'(dc), 10);
      check("post_rst_err", 32'(err_count), 32'(model_err(2)));

      // Full vector range: all outputs wrong, must end at the last index without wrapping.
      for (int i = 0; i < 1024; i++) begin
         dut_tab[i] = 10'h3FF;
         exp_tab[i] = 10'h000;
      end
      run(1023, 0, 0, dc, dp, bc);
      check("full_done_cycle", 32'(dc), 2049);
      check("full_done_pulses", 32'(dp), 1);
      check("full_err", 32'(err_count), 10240);
      check("full_no_wrap", 32'(dut_in), 1023);

`ifdef CGP_EVAL_TOGGLE_EN
      // Alternating outputs per vector.
      for (int i = 0; i < 1024; i++) begin
         dut_tab[i] = (i % 2 == 1) ? 10'h3FF : 10'h000;
         exp_tab[i] = 10'h000;
      end
      run(3, 1, 0, dc, dp, bc);
      check("toggle_count", 32'(tog_count), 32'(model_tog(3)));
      check("toggle_count_abs", 32'(tog_count), 30);
      fill_random(1'b0);
      run(6, 0, 0, dc, dp, bc);
      check("toggle_rand", 32'(tog_count), 32'(model_tog(6)));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
